dma_addr_count_regs: RTL and testbench

Per-channel address and word-count register file for the 8237A-style DMA controller. It sits directly downstream of the software command decoder and consumes its decoded program-mode strobes. It owns four base/current address and base/current word-count registers plus the byte-pointer flip-flop, and drives the 8-bit read-back data bus. On the service side it updates the current registers on every transfer and flags terminal count (TC).

---
 rtl/dma_addr_count_regs.sv | 109 ++++++++++
 tb/tb_dma_addr_count_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_addr_count_regs.sv
// dma_addr_count_regs: 8237A-style per-channel base/current address and word-count
// registers with byte pointer flip-flop, read-back bus and terminal-count detection.
module dma_addr_count_regs (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic        hlda_i,
  input  logic [3:0]  write_base_addr_cmd_i,
  input  logic [3:0]  read_curr_addr_cmd_i,
  input  logic [3:0]  write_base_wc_cmd_i,
  input  logic [3:0]  read_curr_wc_cmd_i,
  input  logic        clear_byte_pointer_cmd_i,
  input  logic        set_byte_pointer_cmd_i,
  input  logic        master_clear_cmd_i,
  input  logic [7:0]  db_in_i,
  output logic [7:0]  db_out_o,
  output logic        db_oe_o,
  input  logic        update_i,
  input  logic [1:0]  update_ch_i,
  input  logic        addr_dec_i,
  input  logic        autoinit_i,
  output logic [15:0] curr_addr_o,
  output logic        tc_o
);
  logic [15:0] base_addr_q [4];
  logic [15:0] base_addr_d [4];
  logic [15:0] curr_addr_q [4];
  logic [15:0] curr_addr_d [4];
  logic [15:0] base_wc_q [4];
  logic [15:0] base_wc_d [4];
  logic [15:0] curr_wc_q [4];
  logic [15:0] curr_wc_d [4];
  logic [18:0] lvl, prev_q, rise;
  logic [3:0]  wba, rca, wbw, rcw, bsel;
  logic        cbp, sbp, mclr, rd_lvl, upd_ok;
  logic        first_q, ff_q, ff_d, oe_q, oe_d, tc_q, tc_d;
  logic [7:0]  db_q, db_d;

  // unqualified strobes may be X, so they are forced to 0 before edge detection
  assign lvl = (!cs_ni && !hlda_i) ? {write_base_addr_cmd_i, read_curr_addr_cmd_i,
    write_base_wc_cmd_i, read_curr_wc_cmd_i, clear_byte_pointer_cmd_i,
    set_byte_pointer_cmd_i, master_clear_cmd_i} : '0;
  // the first cycle after reset only primes the samples, so a held strobe is not an edge
  assign rise = first_q ? '0 : lvl & ~prev_q;
  assign {wba, rca, wbw, rcw, cbp, sbp, mclr} = rise;
  assign rd_lvl = |{lvl[14:11], lvl[6:3]};
  assign bsel = {ff_q, 3'b000};
  assign upd_ok = update_i && !wba[update_ch_i] && !wbw[update_ch_i];
  assign curr_addr_o = curr_addr_q[update_ch_i];
  assign db_out_o = db_q;
  assign db_oe_o = oe_q && rd_lvl;
  assign tc_o = tc_q;

  always_comb begin
    base_addr_d = base_addr_q;
    curr_addr_d = curr_addr_q;
    base_wc_d = base_wc_q;
    curr_wc_d = curr_wc_q;
    db_d = db_q;
    tc_d = 1'b0;
    if (upd_ok) begin
      tc_d = curr_wc_q[update_ch_i] == 16'h0000;
      curr_addr_d[update_ch_i] = (tc_d && autoinit_i) ? base_addr_q[update_ch_i] :
        addr_dec_i ? curr_addr_q[update_ch_i] - 16'd1 : curr_addr_q[update_ch_i] + 16'd1;
      curr_wc_d[update_ch_i] = (tc_d && autoinit_i) ? base_wc_q[update_ch_i] :
        curr_wc_q[update_ch_i] - 16'd1;
    end
    for (int n = 0; n < 4; n++) begin
      if (wba[n]) begin
        base_addr_d[n][bsel +: 8] = db_in_i;
        curr_addr_d[n][bsel +: 8] = db_in_i;
      end
      if (wbw[n]) begin
        base_wc_d[n][bsel +: 8] = db_in_i;
        curr_wc_d[n][bsel +: 8] = db_in_i;
      end
      if (rca[n]) db_d = curr_addr_q[n][bsel +: 8];
      if (rcw[n]) db_d = curr_wc_q[n][bsel +: 8];
    end
    ff_d = (cbp || mclr) ? 1'b0 : sbp ? 1'b1 : (|{wba, rca, wbw, rcw}) ? !ff_q : ff_q;
    oe_d = (|{rca, rcw}) || (oe_q && rd_lvl);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_addr_q <= '{default: '0};
      curr_addr_q <= '{default: '0};
      base_wc_q <= '{default: '0};
      curr_wc_q <= '{default: '0};
      prev_q <= '0;
      first_q <= 1'b1;
      ff_q <= 1'b0;
      db_q <= 8'h00;
      oe_q <= 1'b0;
      tc_q <= 1'b0;
    end else begin
      base_addr_q <= base_addr_d;
      curr_addr_q <= curr_addr_d;
      base_wc_q <= base_wc_d;
      curr_wc_q <= curr_wc_d;
      prev_q <= lvl;
      first_q <= 1'b0;
      ff_q <= ff_d;
      db_q <= db_d;
      oe_q <= oe_d;
      tc_q <= tc_d;
    end
  end
endmodule

// File: tb/tb_dma_addr_count_regs.sv
// tb_dma_addr_count_regs: scoreboard bench; reads and TC pulses are checked by a monitor
// against expectations queued from a behavioural register-file model.
module tb_dma_addr_count_regs;
  logic clk = 0, rst_n = 0, cs_n = 1, hlda = 0;
  logic [3:0] wba = 0, rca = 0, wbw = 0, rcw = 0;
  logic cbp = 0, sbp = 0, mclr = 0;
  logic [7:0] db_in = 0, db_out;
  logic db_oe, tc;
  logic upd = 0, dec = 0, ai = 0;
  logic [1:0] ch = 0;
  logic [15:0] caddr;
  int vectors = 0, errors = 0;
  logic [15:0] m_ba [4], m_ca [4], m_bw [4], m_cw [4];
  bit m_ff;
  logic [7:0] rdq [$];
  bit tcq [$];
  bit upd_seen = 0, oe_prev = 0, exp_tc;
  logic [7:0] exp_db;

  dma_addr_count_regs dut (
    .clk_i(clk), .rst_ni(rst_n), .cs_ni(cs_n), .hlda_i(hlda),
    .write_base_addr_cmd_i(wba), .read_curr_addr_cmd_i(rca),
    .write_base_wc_cmd_i(wbw), .read_curr_wc_cmd_i(rcw),
    .clear_byte_pointer_cmd_i(cbp), .set_byte_pointer_cmd_i(sbp),
    .master_clear_cmd_i(mclr), .db_in_i(db_in), .db_out_o(db_out), .db_oe_o(db_oe),
    .update_i(upd), .update_ch_i(ch), .addr_dec_i(dec), .autoinit_i(ai),
    .curr_addr_o(caddr), .tc_o(tc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_ba[i] = 0; m_ca[i] = 0; m_bw[i] = 0; m_cw[i] = 0;
    end
    m_ff = 0;
  endfunction

  function automatic bit m_upd(int c, bit d, bit a);
    bit t = (m_cw[c] == 16'h0000);
    if (t && a) begin
      m_ca[c] = m_ba[c];
      m_cw[c] = m_bw[c];
    end else begin
      m_ca[c] = d ? m_ca[c] - 16'd1 : m_ca[c] + 16'd1;
      m_cw[c] = m_cw[c] - 16'd1;
    end
    return t;
  endfunction

  function automatic void m_wr(int wc, int c, logic [7:0] b);
    int sh = m_ff ? 8 : 0;
    if (wc != 0) begin
      m_bw[c][sh +: 8] = b; m_cw[c][sh +: 8] = b;
    end else begin
      m_ba[c][sh +: 8] = b; m_ca[c][sh +: 8] = b;
    end
    m_ff = !m_ff;
  endfunction

  task automatic acc_wr(int wc, int c, logic [7:0] b, int hold);
    @(posedge clk); #1;
    cs_n = 0; db_in = b;
    if (wc != 0) wbw[c] = 1; else wba[c] = 1;
    m_wr(wc, c, b);
    repeat (hold) @(posedge clk);
    #1; wba = 0; wbw = 0; cs_n = 1;
  endtask

  task automatic acc_rd(int wc, int c, int hold);
    int sh = m_ff ? 8 : 0;
    rdq.push_back(wc != 0 ? m_cw[c][sh +: 8] : m_ca[c][sh +: 8]);
    m_ff = !m_ff;
    @(posedge clk); #1;
    cs_n = 0;
    if (wc != 0) rcw[c] = 1; else rca[c] = 1;
    @(negedge clk); chk("oe_before_edge", db_oe, 0);
    @(posedge clk);
    @(negedge clk); chk("oe_after_edge", db_oe, 1);
    repeat (hold - 1) @(posedge clk);
    #1; rca = 0; rcw = 0; cs_n = 1;
    @(negedge clk); chk("oe_after_drop", db_oe, 0);
  endtask

  task automatic ptr(int k);
    @(posedge clk); #1;
    cs_n = 0;
    if (k == 0) cbp = 1; else if (k == 1) sbp = 1; else mclr = 1;
    m_ff = (k == 1);
    @(posedge clk); #1;
    cbp = 0; sbp = 0; mclr = 0; cs_n = 1;
  endtask

  task automatic do_upd(int c, bit d, bit a, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      upd = 1; ch = 2'(c); dec = d; ai = a;
      tcq.push_back(m_upd(c, d, a));
    end
    @(posedge clk); #1;
    upd = 0;
    @(negedge clk); chk("curr_addr_after_update", caddr, m_ca[c]);
  endtask

  task automatic chk_ca(int c, logic [15:0] exp);
    ch = 2'(c); #1;
    chk("curr_addr", caddr, exp);
  endtask

  function automatic logic [7:0] rb();
    int r = $urandom_range(0, 5);
    return r < 2 ? 8'h00 : r == 2 ? 8'h01 : 8'($urandom);
  endfunction

  always @(posedge clk) upd_seen <= upd;

  always @(negedge clk) begin
    if (upd_seen) begin
      vectors++;
      if (tcq.size() == 0) begin
        errors++;
        $display("FAIL tc_queue: got update with no expectation, expected queued entry");
      end else begin
        exp_tc = tcq.pop_front();
        if (tc !== exp_tc) begin
          errors++;
          $display("FAIL tc: got %b expected %b", tc, exp_tc);
        end
      end
    end else if (tc !== 1'b0) begin
      vectors++; errors++;
      $display("FAIL tc_spurious: got %b expected 0", tc);
    end
    if (db_oe === 1'b1 && !oe_prev) begin
      vectors++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL db_queue: got read data %h expected no read", db_out);
      end else begin
        exp_db = rdq.pop_front();
        if (db_out !== exp_db) begin
          errors++;
          $display("FAIL db_out: got %h expected %h", db_out, exp_db);
        end
      end
    end
    oe_prev = (db_oe === 1'b1);
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) chk_ca(c, 16'h0000);
    chk("reset_db_oe", db_oe, 0);
    chk("reset_db_out", db_out, 0);
    chk("reset_tc", tc, 0);
    @(negedge clk); rst_n = 1;

    ptr(0);
    acc_wr(0, 2, 8'h34, 1);
    acc_wr(0, 2, 8'h12, 1);
    chk_ca(2, 16'h1234);
    acc_rd(0, 2, 1);
    acc_rd(0, 2, 5);
    acc_rd(0, 2, 1);

    ptr(0);
    acc_wr(0, 0, 8'hFF, 1); acc_wr(0, 0, 8'hFF, 1);
    acc_wr(1, 0, 8'h01, 1); acc_wr(1, 0, 8'h00, 1);
    do_upd(0, 0, 0, 1); chk_ca(0, 16'h0000);
    do_upd(0, 0, 0, 1); chk_ca(0, 16'h0001);
    acc_rd(1, 0, 1); acc_rd(1, 0, 2);

    ptr(0);
    acc_wr(0, 1, 8'h00, 1); acc_wr(0, 1, 8'h01, 1);
    acc_wr(1, 1, 8'h00, 1); acc_wr(1, 1, 8'h00, 1);
    do_upd(1, 0, 1, 1); chk_ca(1, 16'h0100);
    acc_rd(1, 1, 1); acc_rd(1, 1, 1);

    ptr(0);
    acc_wr(0, 1, 8'h77, 1);
    ptr(2);
    acc_wr(0, 1, 8'hAB, 1);
    chk_ca(1, 16'h01AB);

    @(posedge clk); #1;
    cs_n = 1; wba = 4'hx; wbw = 4'hx; db_in = 8'hxx; mclr = 1'bx;
    repeat (2) @(posedge clk); #1;
    cs_n = 0; hlda = 1; wba = 4'hF; rca = 4'hF; rcw = 4'hx; sbp = 1;
    repeat (2) @(posedge clk); #1;
    wba = 0; wbw = 0; rca = 0; rcw = 0; sbp = 0; mclr = 0; db_in = 0; hlda = 0; cs_n = 1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) chk_ca(c, m_ca[c]);
    acc_rd(0, 1, 1);

    acc_wr(1, 3, 8'h00, 1); acc_wr(1, 3, 8'h00, 1);
    acc_wr(0, 3, 8'h20, 1); acc_wr(0, 3, 8'h40, 1);
    @(posedge clk); #1;
    cs_n = 0; wbw[3] = 1; db_in = 8'h05; upd = 1; ch = 3; dec = 0; ai = 0;
    m_wr(1, 3, 8'h05);
    tcq.push_back(1'b0);
    @(posedge clk); #1;
    wbw = 0; upd = 0; cs_n = 1;
    chk_ca(3, 16'h4020);
    ptr(0);
    acc_rd(1, 3, 1); acc_rd(1, 3, 1);

    for (int i = 0; i < 250; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 3) acc_wr($urandom_range(0, 1), $urandom_range(0, 3), rb(), $urandom_range(1, 3));
      else if (r < 5) acc_rd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(1, 3));
      else if (r < 9) do_upd($urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom_range(1, 4));
      else ptr($urandom_range(0, 2));
    end

    ptr(0);
    m_ca[2] = m_ca[2];
    rdq.push_back(m_ca[2][7:0]);
    @(posedge clk); #1;
    cs_n = 0; rca[2] = 1; ch = 2;
    @(posedge clk);
    @(negedge clk); chk("oe_before_reset", db_oe, 1);
    #2 rst_n = 0;
    #1;
    m_reset();
    chk("oe_in_reset", db_oe, 0);
    chk("addr_in_reset", caddr, 16'h0000);
    chk("db_out_in_reset", db_out, 0);
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("oe_held_strobe_after_reset", db_oe, 0);
    #1; rca = 0; cs_n = 1;
    for (int c = 0; c < 4; c++) chk_ca(c, 16'h0000);
    acc_rd(1, 0, 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("read_queue_left", 16'(rdq.size()), 0);
    chk("tc_queue_left", 16'(tcq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
